// File: rtl/pvt_mon_pkg.sv
// Shared types and defaults for the PVT monitor blocks (ring-oscillator meter and
// the readout blocks that follow it).
package pvt_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } fm_state_t;

    localparam int FM_CNT_W  = 16;
    localparam int FM_WIN_W  = 16;
    localparam int FM_SETTLE = 2;

endpackage

// File: rtl/ro_freq_meter_if.sv
// Request/result bundle of the ring-oscillator frequency meter.
// The master issues requests; the slave (the meter) returns results.
interface ro_freq_meter_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (output start, win_len, input busy, done, count, overflow);
    modport slave  (input start, win_len, output busy, done, count, overflow);
endinterface

// File: rtl/pvt_sync2.sv
// Two-flop synchroniser for a single asynchronous bit.
module pvt_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/ro_freq_meter.sv
// Counts rising edges of an asynchronous ring-oscillator output over a window of
// win_len clk cycles, after a short synchroniser flush.
module ro_freq_meter
    // SETTLE is also a parameter name, so the state literal is always package-qualified.
    import pvt_mon_pkg::fm_state_t, pvt_mon_pkg::IDLE, pvt_mon_pkg::COUNT, pvt_mon_pkg::DONE,
           pvt_mon_pkg::FM_CNT_W, pvt_mon_pkg::FM_WIN_W, pvt_mon_pkg::FM_SETTLE;
#(
    parameter int CNT_W  = FM_CNT_W,
    parameter int WIN_W  = FM_WIN_W,
    parameter int SETTLE = FM_SETTLE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          osc_in,
    ro_freq_meter_if.slave bus
);
    localparam int SET_W = $clog2(SETTLE + 1);

    fm_state_t        state_q, state_d;
    logic [WIN_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic osc_s2;
    logic s3_q;
    logic rise;

    pvt_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (osc_in),
        .q   (osc_s2)
    );

    assign rise = osc_s2 & ~s3_q;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        count_d  = count_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remain_d = bus.win_len;
                    acc_d    = '0;
                    sat_d    = 1'b0;
                    settle_d = SET_W'(SETTLE);
                    state_d  = pvt_mon_pkg::SETTLE;
                end
            end
            pvt_mon_pkg::SETTLE: begin
                settle_d = settle_q - SET_W'(1);
                if (settle_q == SET_W'(1)) begin
                    state_d = (remain_q != '0) ? COUNT : DONE;
                end
            end
            COUNT: begin
                if (rise) begin
                    if (acc_q == '1) begin
                        sat_d = 1'b1;
                    end else begin
                        acc_d = acc_q + CNT_W'(1);
                    end
                end
                remain_d = remain_q - WIN_W'(1);
                if (remain_q == WIN_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                count_d = acc_q;
                ovf_d   = sat_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            remain_q <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            settle_q <= '0;
            done_q   <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            s3_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            s3_q     <= osc_s2;
        end
    end

    // The DONE cycle itself is not busy; the result lands on the following edge.
    assign bus.busy     = (state_q == pvt_mon_pkg::SETTLE) || (state_q == COUNT);
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ro_freq_meter.sv
// Self-checking bench for ro_freq_meter: directed vector table, hand-written
// reset/re-arm sequences and randomized windows against a transition-count model.
module tb_ro_freq_meter;
    logic clk = 1'b0;
    logic rst;
    logic osc_in;

    always #5 clk = ~clk;

    ro_freq_meter_if #(.CNT_W(16), .WIN_W(16)) bus  ();
    ro_freq_meter_if #(.CNT_W(4),  .WIN_W(16)) bus4 ();

    ro_freq_meter #(.CNT_W(16), .WIN_W(16), .SETTLE(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .osc_in (osc_in),
        .bus    (bus)
    );

    ro_freq_meter #(.CNT_W(4), .WIN_W(16), .SETTLE(2)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .osc_in (osc_in),
        .bus    (bus4)
    );

    int errors = 0;
    int checks = 0;

    // Oscillator source: 0 = periodic (half period osc_half), 1 = static osc_lvl, 2 = random
    int osc_mode = 1;
    int osc_half = 4;
    bit osc_lvl  = 1'b0;
    int phase    = 0;

    always @(negedge clk) begin
        case (osc_mode)
            0: begin
                phase  = phase + 1;
                osc_in = ((phase / osc_half) % 2) != 0;
            end
            1: osc_in = osc_lvl;
            default: osc_in = $urandom_range(0, 1) != 0;
        endcase
    end

    // hist[k] is the osc_in value present at posedge number k
    bit hist [0:16383];
    int edge_n = 0;

    always @(posedge clk) begin
        if (edge_n < 16384) hist[edge_n] <= osc_in;
        edge_n <= edge_n + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // A window counts the 0->1 transitions among the samples at accept edge .. accept edge + win.
    task automatic model(input int e0, input int win, input int w, output int cnt, output int ovf);
        int raw = 0;
        int mx  = (1 << w) - 1;
        for (int m = 0; m < win; m++) begin
            if (!hist[e0 + m] && hist[e0 + m + 1]) raw++;
        end
        cnt = (raw > mx) ? mx : raw;
        ovf = (raw > mx) ? 1 : 0;
    endtask

    function automatic int get_busy(input bit s);
        return s ? int'(bus4.busy) : int'(bus.busy);
    endfunction
    function automatic int get_done(input bit s);
        return s ? int'(bus4.done) : int'(bus.done);
    endfunction
    function automatic int get_count(input bit s);
        return s ? int'(bus4.count) : int'(bus.count);
    endfunction
    function automatic int get_ovf(input bit s);
        return s ? int'(bus4.overflow) : int'(bus.overflow);
    endfunction

    task automatic set_req(input bit s, input bit st, input int win);
        if (s) begin
            bus4.start   = st;
            bus4.win_len = 16'(win);
        end else begin
            bus.start    = st;
            bus.win_len  = 16'(win);
        end
    endtask

    // One measurement; pulse_at >= 0 re-requests (win_len 5) at that cycle to probe lockout.
    task automatic run(input string name, input bit s, input int win, input int pulse_at,
                       input int exp_cnt, input int exp_ovf, input bit use_model);
        int e0, busy_n, done_edge, ndone, cap_cnt, cap_ovf, ec, eo;
        busy_n = 0; done_edge = -1; ndone = 0; cap_cnt = -1; cap_ovf = -1;
        @(negedge clk);
        e0 = edge_n;
        set_req(s, 1'b1, win);
        @(negedge clk);
        set_req(s, 1'b0, int'($urandom_range(0, 65535)));
        for (int i = 0; i < win + 22; i++) begin
            if (get_busy(s) != 0) busy_n++;
            if (get_done(s) != 0) begin
                ndone++;
                if (done_edge < 0) begin
                    done_edge = edge_n - 1;
                    cap_cnt   = get_count(s);
                    cap_ovf   = get_ovf(s);
                end
            end
            if (i == pulse_at) set_req(s, 1'b1, 5);
            if (i == pulse_at + 1) set_req(s, 1'b0, 5);
            @(negedge clk);
        end
        if (use_model) model(e0, win, s ? 4 : 16, ec, eo);
        else begin
            ec = exp_cnt;
            eo = exp_ovf;
        end
        chk({name, " done_pulses"}, ndone, 1);
        chk({name, " done_edge"}, done_edge - e0, win + 3);
        chk({name, " busy_cycles"}, busy_n, win + 2);
        chk({name, " count"}, cap_cnt, ec);
        chk({name, " overflow"}, cap_ovf, eo);
        chk({name, " count_held"}, get_count(s), ec);
        $display("run %s: win=%0d count=%0d ovf=%0d expected %0d/%0d", name, win, cap_cnt, cap_ovf, ec, eo);
    endtask

    typedef struct {
        string name;
        int    mode;
        int    half;
        bit    lvl;
        bit    use4;
        int    win;
        int    pulse;
        int    exp_cnt;
        int    exp_ovf;
    } vec_t;

    vec_t vt [8];

    initial begin
        int e0, ndone, d1, d2;
        vt[0] = '{"basic",     0, 4, 1'b0, 1'b0, 64,  -1, 8,  0};
        vt[1] = '{"zero_win",  0, 4, 1'b0, 1'b0, 0,   -1, 0,  0};
        vt[2] = '{"saturate",  0, 2, 1'b0, 1'b1, 100, -1, 15, 1};
        vt[3] = '{"after_sat", 0, 2, 1'b0, 1'b1, 20,  -1, 5,  0};
        vt[4] = '{"lockout",   0, 4, 1'b0, 1'b0, 32,  10, 4,  0};
        vt[5] = '{"after_lock",0, 4, 1'b0, 1'b0, 16,  -1, 2,  0};
        vt[6] = '{"static_hi", 1, 4, 1'b1, 1'b0, 40,  -1, 0,  0};
        vt[7] = '{"static_lo", 1, 4, 1'b0, 1'b0, 40,  -1, 0,  0};

        rst = 1'b1;
        set_req(1'b0, 1'b0, 0);
        set_req(1'b1, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset count", int'(bus.count), 0);
        chk("reset overflow", int'(bus.overflow), 0);
        chk("reset count4", int'(bus4.count), 0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            osc_mode = vt[v].mode;
            osc_half = vt[v].half;
            osc_lvl  = vt[v].lvl;
            repeat (4) @(negedge clk);
            run(vt[v].name, vt[v].use4, vt[v].win, vt[v].pulse, vt[v].exp_cnt, vt[v].exp_ovf, 1'b0);
        end

        // Reset mid-COUNT: rst sampled at accept edge + 20
        osc_mode = 0;
        osc_half = 4;
        @(negedge clk);
        e0 = edge_n;
        set_req(1'b0, 1'b1, 50);
        @(negedge clk);
        set_req(1'b0, 1'b0, 50);
        while (edge_n < e0 + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", int'(bus.busy), 0);
        chk("midrst done", int'(bus.done), 0);
        chk("midrst count", int'(bus.count), 0);
        chk("midrst overflow", int'(bus.overflow), 0);
        ndone = 0;
        repeat (60) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        chk("midrst no_done", ndone, 0);
        $display("run midrst: busy=%0d count=%0d stray_done=%0d", bus.busy, bus.count, ndone);
        run("post_rst", 1'b0, 16, -1, 2, 0, 1'b0);

        // start held high re-arms: dones at accept edge + 7 and + 15 for win_len 4
        @(negedge clk);
        e0 = edge_n;
        set_req(1'b0, 1'b1, 4);
        d1 = -1;
        d2 = -1;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) begin
                if (d1 < 0) d1 = edge_n - 1 - e0;
                else if (d2 < 0) d2 = edge_n - 1 - e0;
            end
        end
        set_req(1'b0, 1'b0, 4);
        chk("rearm first_done", d1, 7);
        chk("rearm second_done", d2, 15);
        $display("run rearm: done edges +%0d and +%0d", d1, d2);
        repeat (20) @(negedge clk);

        // Random oscillator, random windows, compared against the transition-count model
        osc_mode = 2;
        for (int r = 0; r < 20; r++) begin
            run($sformatf("rand%0d", r), $urandom_range(0, 1) != 0, int'($urandom_range(0, 40)),
                -1, 0, 0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Single-clock frequency meter for the on-die ring oscillators (inverter and NAND2 rings). It counts rising edges of a ring-oscillator output over a programmable window of `clk` cycles. The result replaces raw oscillator observation with a readable count that the top-level output mux selects onto `uio_out`. The block synchronises the asynchronous oscillator itself, so the ring's `osc_out` connects straight to `osc_in`.

## Interface
- `CNT_W`, 16: width of edge count result.
- `WIN_W`, 16: width of window length.
- `SETTLE`, 2: synchroniser flush cycles before counting starts; must be ≥ 2.

Ports:
- `clk`  in  1  measurement clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `osc_in`  in  1  asynchronous ring-oscillator output. Usage rule: f_osc ≤ f_clk/4; a faster ring goes through a divider first.
- `start`  in  1  level-sampled request; accepted only in IDLE.
- `win_len`  in  WIN_W  window length in `clk` cycles; latched on accept.
- `busy`  out  1  high from the cycle after accept until DONE.
- `done`  out  1  one-cycle pulse; `count`/`overflow` are valid from this cycle.
- `count`  out  CNT_W  rising edges seen in the last completed window; held until the next DONE.
- `overflow`  out  1  last window saturated `count`; held with `count`.

## Operation
- Synchroniser: two flops s1, s2 on `osc_in`, plus history flop s3. rise = s2 & ~s3. All three run in every state, including reset.
- FSM states are IDLE, SETTLE, COUNT and DONE.
  - IDLE: when `start`=1, latch `win_len` into `remain`, clear `acc`, clear the internal sat flag, load the settle counter with SETTLE, and go to SETTLE.
  - SETTLE: decrement the settle counter. At the last SETTLE cycle, go to COUNT if `remain`≠0; otherwise go to DONE.
  - COUNT: each cycle, `acc` += rise with saturation at 2^CNT_W−1; the sat flag is set if an increment occurs while `acc` is at max. `remain` decrements. When `remain`==1, go to DONE.
  - DONE: `done`=1, `count`←`acc`, `overflow`←sat flag. Unconditionally go to IDLE.
- `start` is ignored in SETTLE, COUNT and DONE. A request needs `start` high in IDLE.
- `start` held high re-arms: the cycle after DONE is IDLE, and the next edge accepts again.
- `win_len` changes after accept have no effect.
- Edges are counted only in COUNT cycles. An edge whose rise falls in SETTLE or DONE is discarded.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `count`=0, `overflow`=0, `acc`=0, s1/s2/s3=0.
- `rst` mid-measurement forces IDLE at the next edge with the values above. No `done` is produced and the previous `count` is cleared.
- With `start` sampled at edge E0:
  - `busy`=1 from E0 to E(SETTLE+win_len).
  - COUNT occupies the win_len cycles after E(SETTLE).
  - `done`=1 and the new `count` appear after E(SETTLE+win_len+1), with `busy`=0 in that same cycle.
- `win_len`=0: `done` appears after E(SETTLE+1) with `count`=0 and `overflow`=0.
- Input-to-count latency: an `osc_in` rise is reflected in rise 2–3 clocks later. Edges within the final 2 clocks of the window are therefore attributed out of window; ±1 count quantisation is accepted.
- `remain` is WIN_W bits; the maximum window is 2^WIN_W−1 cycles with no wrap.
- The settle counter width is $clog2(SETTLE+1).

## Structure
- Package `pvt_mon_pkg`:
  - enum `fm_state_t` {IDLE, SETTLE, COUNT, DONE}.
  - localparam defaults FM_CNT_W=16, FM_WIN_W=16, FM_SETTLE=2.
  - Reused by later monitor readout blocks.
- Sub-module `pvt_sync2`: two-flop synchroniser, parameterless, 1 bit. Reused for the skew and clock-q blocks' asynchronous controls.
- `ro_freq_meter` holds the FSM, the counters and the result registers. Expected size is about 150 lines.

## Test plan
- Basic count: `osc_in` period 8 clk (4 high/4 low) is free-running. Start with `win_len`=64 → `done` after E67, `count`=8, `overflow`=0, `busy` high for exactly 66 cycles.
- Zero window: `win_len`=0, `osc_in` toggling → `done` after E3, `count`=0, `overflow`=0.
- Saturation: CNT_W=4, `osc_in` period 4, `win_len`=100 → `count`=15, `overflow`=1. A following run with `win_len`=20 → `count`=5, `overflow`=0.
- Busy lockout: accept with `win_len`=32, then pulse `start` during COUNT with `win_len`=5 → only one `done`, at E35. The next `start` accepts normally.
- Reset mid-COUNT: start `win_len`=50, assert `rst` for 1 cycle at E20 → no `done`, `busy`=0, `count`=0. A subsequent run with `win_len`=16 and period 8 → `count`=2.
- Static input: `osc_in` held at 1 across accept, `win_len`=40 → `count`=0; also cover `osc_in` held at 0.
